// File: rtl/pwm_fade_pkg.sv
// Shared types and default widths for the PWM fade sequencer.
// The hold states exist only when PWM_FADE_HOLD_EN is defined.
package pwm_fade_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_STEP_W    = 4;
  localparam int DEF_HOLD_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DOWN = 3'd2
`ifdef PWM_FADE_HOLD_EN
    ,
    ST_HOLD_HIGH = 3'd3,
    ST_HOLD_LOW  = 3'd4
`endif
  } pwm_fade_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period counter: counts 0..max_value_i while enabled and flags the last
// clock of each period on tick_o.
module pwm_period_timer #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [BIT_WIDTH-1:0] max_value_i,
  output logic                 tick_o
);

  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 at_max;

  assign at_max = (cnt_q == max_value_i);
  assign tick_o = enable_i & at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = at_max ? '0 : cnt_q + BIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Triangle fade of a PWM duty value between two endpoints, one step per period.
// Define PWM_FADE_HOLD_EN to add a dwell of hold_periods at each endpoint.
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int HOLD_W    = DEF_HOLD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic [BIT_WIDTH-1:0] max_value,
  input  logic [BIT_WIDTH-1:0] duty_min,
  input  logic [BIT_WIDTH-1:0] duty_max,
  input  logic [STEP_W-1:0]    step,
  input  logic [HOLD_W-1:0]    hold_periods,
  output logic [BIT_WIDTH-1:0] duty,
  output logic                 period_tick,
  output logic                 busy,
  output logic                 done,
  output pwm_fade_state_e      state_o
);

  pwm_fade_state_e      state_q, state_d;
  logic [BIT_WIDTH-1:0] duty_q, duty_d;
  logic                 done_q, done_d;
  logic [BIT_WIDTH-1:0] max_q, max_d, min_q, min_d, top_q, top_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [BIT_WIDTH:0]   step_ext, up_sum, dn_floor;
  logic                 tick, cnt_clr, finish;

`ifdef PWM_FADE_HOLD_EN
  logic [HOLD_W-1:0]    hold_q, hold_d, hold_cnt_q, hold_cnt_d;
  logic                 hold_last;
  assign hold_last = (hold_cnt_q == hold_q - HOLD_W'(1));
`else
  logic unused_hold;
  assign unused_hold = ^hold_periods;
`endif

  // Endpoint tests are one bit wider so neither direction can wrap.
  assign step_ext = (BIT_WIDTH+1)'(step_q);
  assign up_sum   = {1'b0, duty_q} + step_ext;
  assign dn_floor = {1'b0, min_q} + step_ext;

  assign busy        = (state_q != ST_IDLE);
  assign duty        = duty_q;
  assign done        = done_q;
  assign period_tick = tick;
  assign state_o     = state_q;

  pwm_period_timer #(.BIT_WIDTH(BIT_WIDTH)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (busy),
    .clear_i    (cnt_clr),
    .max_value_i(max_q),
    .tick_o     (tick)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    max_d   = max_q;
    min_d   = min_q;
    top_d   = top_q;
    step_d  = step_q;
`ifdef PWM_FADE_HOLD_EN
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
`endif
    cnt_clr = 1'b0;
    finish  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            max_d   = max_value;
            min_d   = duty_min;
            top_d   = duty_max;
            step_d  = (step == '0) ? STEP_W'(1) : step;
`ifdef PWM_FADE_HOLD_EN
            hold_d  = hold_periods;
`endif
            duty_d  = duty_min;
            cnt_clr = 1'b1;
            // A degenerate range completes immediately without ramping.
            if (duty_min >= duty_max) done_d = 1'b1;
            else                      state_d = ST_RAMP_UP;
          end
        end
        ST_RAMP_UP: begin
          if (tick) begin
            if (up_sum >= {1'b0, top_q}) begin
              duty_d = top_q;
`ifdef PWM_FADE_HOLD_EN
              hold_cnt_d = '0;
              state_d    = (hold_q == '0) ? ST_RAMP_DOWN : ST_HOLD_HIGH;
`else
              state_d = ST_RAMP_DOWN;
`endif
            end else begin
              duty_d = up_sum[BIT_WIDTH-1:0];
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (tick) begin
            if ({1'b0, duty_q} <= dn_floor) begin
              duty_d = min_q;
`ifdef PWM_FADE_HOLD_EN
              hold_cnt_d = '0;
              if (hold_q == '0) finish  = 1'b1;
              else              state_d = ST_HOLD_LOW;
`else
              finish = 1'b1;
`endif
            end else begin
              duty_d = duty_q - step_ext[BIT_WIDTH-1:0];
            end
          end
        end
`ifdef PWM_FADE_HOLD_EN
        ST_HOLD_HIGH: begin
          if (tick) begin
            if (hold_last) state_d    = ST_RAMP_DOWN;
            else           hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_HOLD_LOW: begin
          if (tick) begin
            if (hold_last) finish     = 1'b1;
            else           hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
      if (finish) begin
        done_d  = 1'b1;
        state_d = loop ? ST_RAMP_UP : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      done_q  <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
      top_q   <= '0;
      step_q  <= '0;
`ifdef PWM_FADE_HOLD_EN
      hold_q     <= '0;
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
      max_q   <= max_d;
      min_q   <= min_d;
      top_q   <= top_d;
      step_q  <= step_d;
`ifdef PWM_FADE_HOLD_EN
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: per-period duty-list model checked every cycle,
// plus directed literal checks; follows PWM_FADE_HOLD_EN like the design.
module tb_pwm_fade_sequencer;
  import pwm_fade_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop;
  logic [7:0] max_value, duty_min, duty_max;
  logic [3:0] step;
  logic [7:0] hold_periods;
  logic [7:0] duty;
  logic       period_tick, busy, done;
  pwm_fade_state_e state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  int t1_exp[8] = '{0, 5, 10, 15, 20, 15, 10, 5};

  always #5 clk = ~clk;

  pwm_fade_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .max_value   (max_value),
    .duty_min    (duty_min),
    .duty_max    (duty_max),
    .step        (step),
    .hold_periods(hold_periods),
    .duty        (duty),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done),
    .state_o     (state_dbg)
  );

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: at start, the whole fade is unrolled into the duty value of
  // every busy period; time then just indexes into that list.
  int m_list[$];
  bit m_valid = 0;
  bit m_act = 0;
  bit m_done = 0;
  bit m_tick = 0;
  int m_duty = 0;
  int m_idx = 0;
  int m_per = 1;
  int m_min = 0;

  function automatic void build_list(input int mn, input int mx, input int s, input int h);
    int d;
    m_list.delete();
    if (s == 0) s = 1;
    d = mn;
    m_list.push_back(d);
    while (d + s < mx) begin
      d += s;
      m_list.push_back(d);
    end
    d = mx;
    for (int i = 0; i < h; i++) m_list.push_back(mx);
    m_list.push_back(d);
    while (d > mn + s) begin
      d -= s;
      m_list.push_back(d);
    end
    for (int i = 0; i < h; i++) m_list.push_back(mn);
  endfunction

  always @(posedge clk) begin
    int h;
    m_valid = 1;
    if (!rst_n) begin
      m_act = 0; m_duty = 0; m_done = 0; m_idx = 0;
    end else if (stop) begin
      m_act = 0; m_duty = 0; m_done = 0;
    end else if (!m_act) begin
      m_done = 0;
      if (start) begin
        m_duty = duty_min;
        m_min  = duty_min;
        if (duty_min >= duty_max) begin
          m_done = 1;
        end else begin
`ifdef PWM_FADE_HOLD_EN
          h = hold_periods;
`else
          h = 0;
`endif
          build_list(duty_min, duty_max, step, h);
          m_per = max_value + 1;
          m_idx = 0;
          m_act = 1;
        end
      end
    end else begin
      m_done = 0;
      m_idx++;
      if (m_idx == m_per * m_list.size()) begin
        m_done = 1;
        m_duty = m_min;
        if (loop) m_idx = 0;
        else      m_act = 0;
      end else begin
        m_duty = m_list[m_idx / m_per];
      end
    end
    m_tick = m_act && ((m_idx % m_per) == m_per - 1);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("duty", duty, m_duty);
      check("busy", busy, m_act);
      check("done", done, m_done);
      check("period_tick", period_tick, m_tick);
      check("state_vs_busy", int'(state_dbg != ST_IDLE), m_act);
      if (done) n_done++;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int mv, input int mn, input int mx, input int st, input int hp);
    max_value    = 8'(mv);
    duty_min     = 8'(mn);
    duty_max     = 8'(mx);
    step         = 4'(st);
    hold_periods = 8'(hp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick_n(1);
      i++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    cfg(0, 0, 0, 0, 0);
    tick_n(3);
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tick", period_tick, 0);
    rst_n = 1'b1;
    tick_n(1);

    // Basic triangle, 10-clock periods.
    cfg(9, 0, 20, 5, 0);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      check("t1_duty_seq", duty, t1_exp[k]);
      tick_n(10);
    end
    check("t1_end_duty", duty, 0);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    tick_n(1);
    check("t1_done_clear", done, 0);

    // Saturating peak and underflow-free descent.
    cfg(3, 0, 18, 5, 0);
    pulse_start();
    tick_n(16);
    check("t2_peak", duty, 18);
    tick_n(12);
    check("t2_low3", duty, 3);
    tick_n(4);
    check("t2_floor", duty, 0);
    check("t2_done", done, 1);
    tick_n(2);

    // step of 0 behaves as 1.
    cfg(1, 0, 3, 0, 0);
    pulse_start();
    tick_n(6);
    check("t3_step0_peak", duty, 3);
    wait_idle(50);
    tick_n(2);

`ifdef PWM_FADE_HOLD_EN
    cfg(1, 0, 10, 5, 3);
    pulse_start();
    tick_n(4);
    check("t4_hold_hi_a", duty, 10);
    tick_n(2);
    check("t4_hold_hi_b", duty, 10);
    tick_n(2);
    check("t4_hold_hi_c", duty, 10);
    tick_n(4);
    check("t4_down", duty, 5);
    tick_n(2);
    check("t4_hold_lo", duty, 0);
    check("t4_hold_lo_busy", busy, 1);
    tick_n(6);
    check("t4_done", done, 1);
`else
    cfg(1, 0, 10, 5, 3);
    pulse_start();
    tick_n(8);
    check("t4_no_hold_done", done, 1);
    check("t4_no_hold_duty", duty, 0);
`endif
    tick_n(2);

    // stop during RAMP_UP.
    cfg(3, 0, 20, 5, 0);
    pulse_start();
    tick_n(6);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
    check("t5_stop_duty", duty, 0);
    check("t5_stop_busy", busy, 0);
    check("t5_stop_done", done, 0);
    tick_n(3);

    // Degenerate range, then start and stop together.
    cfg(3, 30, 30, 0, 0);
    pulse_start();
    check("t6_degen_duty", duty, 30);
    check("t6_degen_done", done, 1);
    check("t6_degen_busy", busy, 0);
    tick_n(1);
    check("t6_degen_done_clear", done, 0);
    check("t6_degen_hold", duty, 30);
    start = 1'b1; stop = 1'b1;
    tick_n(1);
    start = 1'b0; stop = 1'b0;
    check("t7_ss_duty", duty, 0);
    check("t7_ss_busy", busy, 0);
    check("t7_ss_done", done, 0);
    tick_n(2);

    // Looping, with a start and input changes mid-fade.
    cfg(1, 0, 10, 5, 0);
    loop = 1'b1;
    pulse_start();
    d0 = n_done;
    tick_n(3);
    duty_max = 8'd100;
    step = 4'd1;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    tick_n(40);
    check("t8_loop_peak", duty, 10);
    check("t8_loop_dones", n_done - d0, 5);
    loop = 1'b0;
    wait_idle(50);
    tick_n(2);
    check("t8_final_dones", n_done - d0, 6);

    // Reset mid-fade.
    cfg(3, 0, 20, 5, 0);
    pulse_start();
    tick_n(6);
    rst_n = 1'b0;
    tick_n(1);
    check("t9_rst_duty", duty, 0);
    check("t9_rst_busy", busy, 0);
    check("t9_rst_done", done, 0);
    check("t9_rst_tick", period_tick, 0);
    rst_n = 1'b1;
    tick_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, which sets the width of the duty and period values; it SHALL equal the downstream PWM width.
REQ-002 The block SHALL have parameter STEP_W, default 4, which sets the width of the duty increment per period.
REQ-003 The block SHALL have parameter HOLD_W, default 8, which sets the width of the dwell count in PWM periods.
REQ-004 The block SHALL have port clk  input  1  system clock.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port start  input  1  single-cycle request to begin a fade cycle.
REQ-007 The block SHALL have port stop  input  1  abort request.
REQ-008 The block SHALL have port loop  input  1  repeat the fade when a cycle completes.
REQ-009 The block SHALL have port max_value  input  BIT_WIDTH  PWM terminal count; the period is max_value+1 clocks.
REQ-010 The block SHALL have ports duty_min and duty_max  input  BIT_WIDTH each  fade endpoints.
REQ-011 The block SHALL have port step  input  STEP_W  duty change per period.
REQ-012 The block SHALL have port hold_periods  input  HOLD_W  dwell at each endpoint, in periods.
REQ-013 The block SHALL have port duty  output  BIT_WIDTH  registered duty value for the downstream PWM.
REQ-014 The block SHALL have ports period_tick, busy and done  output  1 each  period boundary, active, and cycle complete.

Function
REQ-015 On an accepted start, the block SHALL capture max_value, duty_min, duty_max, step and hold_periods, set duty to duty_min, clear the period counter, and enter RAMP_UP on the next cycle.
REQ-016 While the block is busy, a period counter SHALL count from 0 to the captured max_value and wrap; period_tick SHALL be high for exactly the cycle in which the counter equals max_value.
REQ-017 The duty output SHALL change only on the clock edge at which period_tick is high (one update per PWM period), except on start, stop and reset.
REQ-018 The states SHALL be IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN and HOLD_LOW.
REQ-019 In RAMP_UP on each tick, the sum duty+step SHALL be computed BIT_WIDTH+1 bits wide; if the sum is at least duty_max, duty SHALL be set to duty_max and the state SHALL go to HOLD_HIGH, otherwise duty SHALL be set to duty+step.
REQ-020 In RAMP_DOWN on each tick, if duty is at most duty_min+step (computed BIT_WIDTH+1 wide, so it cannot underflow), duty SHALL be set to duty_min and the state SHALL go to HOLD_LOW, otherwise duty SHALL be set to duty-step.
REQ-021 In HOLD_HIGH and HOLD_LOW, the block SHALL count ticks and leave the state after hold_periods ticks; HOLD_HIGH SHALL exit to RAMP_DOWN and HOLD_LOW SHALL exit to completion.
REQ-022 On completion, done SHALL pulse for one cycle; the next state SHALL be RAMP_UP if loop is high in that cycle, otherwise IDLE with duty held at duty_min.
REQ-023 busy SHALL be high in every state other than IDLE.
REQ-024 A step value of 0 SHALL be treated as 1.
REQ-025 If duty_min is at least duty_max at start, duty SHALL be set to duty_min and done SHALL pulse on the next cycle, with a return to IDLE and no ramping.
REQ-026 A start received while busy SHALL be ignored, and input changes made while busy SHALL have no effect until the next start.
REQ-027 stop SHALL have priority over start and over every state transition: the next cycle SHALL give IDLE with duty=0 and busy=0, and done SHALL not pulse.
REQ-028 If start and stop are high in the same cycle, the result SHALL be IDLE with duty=0.

Reset
REQ-029 When rst_n is low, the block SHALL set state=IDLE, duty=0, period_tick=0, busy=0, done=0, and clear all counters and captured registers.
REQ-030 A reset during any state SHALL take effect on the next edge and abandon the fade with no done pulse.

Configuration
REQ-031 When macro PWM_FADE_HOLD_EN is defined, the HOLD_HIGH and HOLD_LOW states and the hold counter SHALL exist, and hold_periods=0 SHALL skip the dwell; the exit SHALL occur on the same tick that reaches the endpoint.
REQ-032 When PWM_FADE_HOLD_EN is undefined, there SHALL be no hold states or counter, hold_periods SHALL be ignored, and the endpoint transitions SHALL go directly RAMP_UP to RAMP_DOWN and RAMP_DOWN to completion.

Structure
REQ-033 A package pwm_fade_pkg SHALL hold the state enum typedef and the default width constants.
REQ-034 The period counter and period_tick generation SHALL be a sub-module, pwm_period_timer, with enable, clear and max_value inputs and a tick output.

Verification
REQ-035 With max_value=9, duty_min=0, duty_max=20, step=5, hold_periods=0 and loop=0, a start SHALL give duty 0,5,10,15,20,15,10,5,0 changing every 10 clocks, followed by one done pulse and busy=0.
REQ-036 With duty_max=18, step=5 and duty_min=0, the ramp SHALL saturate at 18 without wrap, and the down ramp from 3 SHALL stop at 0 without underflow.
REQ-037 With PWM_FADE_HOLD_EN defined and hold_periods=3, the duty SHALL stay at duty_max for 3 ticks and at duty_min for 3 ticks.
REQ-038 Asserting stop mid RAMP_UP, and separately asserting start and stop in the same cycle, SHALL each give duty=0, busy=0 and no done pulse on the next cycle.
REQ-039 With loop=1, there SHALL be continuous cycles with one done pulse per cycle; a start while busy SHALL be ignored, and an input change mid-fade SHALL have no effect.
REQ-040 With duty_min=30, duty_max=30 and step=0, a start SHALL give duty=30 and done one cycle later; rst_n low mid-fade SHALL give all outputs 0 on the next edge.
